// File: rtl/ldr_pkg.sv
// ---------------------------------------------------------------------------
// ldr_pkg -- definitions shared by the boot-time program loader.
//   ST_*         : state encodings of the loader FSM.
//   ldr_state_e  : enumerated state type built from those encodings.
//   WORD_W       : instruction word width, shared with the instruction memory.
// ---------------------------------------------------------------------------
package ldr_pkg;

   localparam int WORD_W = 32;

   localparam logic [2:0] ST_HDR  = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_CHK  = 3'd2;
   localparam logic [2:0] ST_DONE = 3'd3;
   localparam logic [2:0] ST_ERR  = 3'd4;

   typedef enum logic [2:0] {
      S_HDR  = ST_HDR,
      S_LOAD = ST_LOAD,
      S_CHK  = ST_CHK,
      S_DONE = ST_DONE,
      S_ERR  = ST_ERR
   } ldr_state_e;

endpackage

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader -- receives a framed word stream (length N, N payload words,
// checksum = XOR of length and payload) and writes the payload into the
// instruction memory, holding the CPU in reset until the checksum verifies.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   s_valid/s_data  : input word stream
//   s_ready         : loader accepts a word (HDR, LOAD, CHK states)
//   reload          : restart frame reception from DONE or ERR
//   im_we/im_addr/im_wdata : instruction-memory write port (1-cycle latency)
//   cpu_rst         : CPU reset, released only once the frame verified
//   done / err      : frame verified / frame rejected (sticky)
//   word_cnt        : payload words written in the current frame
// ---------------------------------------------------------------------------
module prog_loader
   import ldr_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   input  logic [WORD_W-1:0] s_data,
   output logic              s_ready,
   input  logic              reload,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [WORD_W-1:0] im_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_cnt
);

   // Words available from BASE to the top of memory. Held in 33 bits so a
   // length word near 2^32 is compared without aliasing.
   localparam logic [WORD_W:0]   CAP    = (33'd1 << ADDR_W) - 33'(BASE);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

   ldr_state_e          state_q, state_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [WORD_W-1:0]   xor_q, xor_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic                beat;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_HDR;
         cnt_q   <= '0;
         rem_q   <= '0;
         xor_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         xor_q   <= xor_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      xor_d   = xor_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      s_ready = (state_q == S_HDR) || (state_q == S_LOAD) || (state_q == S_CHK);
      beat    = s_valid && s_ready;

      case (state_q)
         S_HDR: begin
            if (beat) begin
               // Truncation is harmless: oversized lengths go to ERR below.
               rem_d = s_data[ADDR_W:0];
               xor_d = s_data;
               cnt_d = '0;
               if ({1'b0, s_data} > CAP)
                  state_d = S_ERR;
               else if (s_data == '0)
                  state_d = S_CHK;
               else
                  state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (beat) begin
               we_d    = 1'b1;
               addr_d  = BASE_A + cnt_q[ADDR_W-1:0];
               wdata_d = s_data;
               xor_d   = xor_q ^ s_data;
               cnt_d   = cnt_q + 1'b1;
               rem_d   = rem_q - 1'b1;
               if (rem_q == (ADDR_W+1)'(1))
                  state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (beat) begin
               if (s_data == xor_q)
                  state_d = S_DONE;
               else
                  state_d = S_ERR;
            end
         end
         S_DONE, S_ERR: begin
            if (reload) begin
               state_d = S_HDR;
               cnt_d   = '0;
               rem_d   = '0;
               xor_d   = '0;
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   assign im_we    = we_q;
   assign im_addr  = addr_q;
   assign im_wdata = wdata_q;
   assign word_cnt = cnt_q;
   assign done     = (state_q == S_DONE);
   assign err      = (state_q == S_ERR);
   // DONE is entered on the checksum beat, which is never earlier than the
   // last payload beat, so the release always follows the last write.
   assign cpu_rst  = (state_q != S_DONE);

endmodule
